calc_sequencer: RTL and testbench

Operand-entry and execution controller for the GoBoard 4-bit calculator datapath. It takes four already-debounced push-button levels and detects their rising edges. It sequences a state machine through entry of operand A, entry of operand B, one execute cycle and a result display. It drives the 4-bit value feeding the 7-segment converter, a blank control for blinking during entry, and four status LEDs. It replaces ad-hoc button handling in the top level; debouncers sit upstream and the binary-to-7-segment converter sits downstream.

---
 rtl/calc_sequencer.sv | 143 ++++++++++++++
 tb/tb_calc_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Operand-entry/execute controller for the 4-bit calculator: button edge detect, A/B entry, one-cycle execute, result display.
// Every output is decoded from registers, so any button effect shows up one cycle after the edge that samples it.
module calc_sequencer #(
    parameter int BLINK_CYCLES = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic [3:0] o_Digit,
    output logic       o_Blank,
    output logic       o_Result_Valid,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4
);

    typedef enum logic [1:0] {ENTER_A, ENTER_B, EXEC, SHOW} state_t;

    localparam int              CW   = 23;
    localparam logic [CW-1:0]   TERM = CW'(BLINK_CYCLES - 1);

    state_t        state_q, state_d;
    logic [3:0]    prev_q;
    logic [3:0]    e_q, e_d, a_q, a_d, b_q, b_d;
    logic          op_q, op_d;
    logic [4:0]    r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    logic [3:0]    sw, ev;
    logic          ev_clr, ev_cfm, ev_op, ev_stp, restart;

    // Bit order matches priority: 3=CLEAR, 1=CONFIRM, 2=OP, 0=STEP
    assign sw     = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
    assign ev     = sw & ~prev_q;
    assign ev_clr = ev[3];
    assign ev_cfm = ev[1] & ~ev[3];
    assign ev_op  = ev[2] & ~ev[1] & ~ev[3];
    assign ev_stp = ev[0] & ~ev[2] & ~ev[1] & ~ev[3];

    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        r_d     = r_q;
        restart = 1'b0;
        if (ev_clr) begin
            state_d = ENTER_A;
            e_d     = 4'd0;
            a_d     = 4'd0;
            b_d     = 4'd0;
            r_d     = 5'd0;
            restart = 1'b1;
        end else begin
            case (state_q)
                ENTER_A, ENTER_B: begin
                    if (ev_cfm) begin
                        if (state_q == ENTER_A) begin
                            a_d     = e_q;
                            e_d     = 4'd0;
                            state_d = ENTER_B;
                        end else begin
                            b_d     = e_q;
                            state_d = EXEC;
                        end
                    end else if (ev_op) begin
                        op_d = ~op_q;
                    end else if (ev_stp) begin
                        e_d     = e_q + 4'd1;
                        restart = 1'b1;
                    end
                end
                EXEC: begin
                    if (op_q)
                        r_d = {(a_q < b_q), 4'(a_q - b_q)};
                    else
                        r_d = {1'b0, a_q} + {1'b0, b_q};
                    state_d = SHOW;
                end
                SHOW: begin
                    if (ev_cfm) begin
                        e_d     = 4'd0;
                        state_d = ENTER_A;
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    // Blink restarts visible on every state change, CLEAR or STEP; held at zero outside entry
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (restart || (state_d != state_q) ||
            (state_d != ENTER_A && state_d != ENTER_B)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == TERM) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= ENTER_A;
            prev_q  <= sw;
            e_q     <= 4'd0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            op_q    <= 1'b0;
            r_q     <= 5'd0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= sw;
            e_q     <= e_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign o_Digit        = (state_q == SHOW) ? r_q[3:0] : e_q;
    assign o_Blank        = phase_q;
    assign o_Result_Valid = (state_q == SHOW);
    assign o_LED_1        = (state_q == ENTER_A);
    assign o_LED_2        = (state_q == ENTER_B);
    assign o_LED_3        = op_q;
    assign o_LED_4        = (state_q == SHOW) & r_q[4];

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: hand-computed vector table, corner-case sequences, and random stimulus
// compared each cycle against an abstract model of the calculator.
module tb_calc_sequencer;

    localparam int N = 4;
    localparam logic [3:0] S = 4'b0001, C = 4'b0010, O = 4'b0100, K = 4'b1000;
    localparam int M_EA = 0, M_EB = 1, M_EX = 2, M_SH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] sw;
    logic [3:0] o_Digit;
    logic       o_Blank, o_Result_Valid, o_LED_1, o_LED_2, o_LED_3, o_LED_4;

    calc_sequencer #(.BLINK_CYCLES(N)) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Switch_1    (sw[0]),
        .i_Switch_2    (sw[1]),
        .i_Switch_3    (sw[2]),
        .i_Switch_4    (sw[3]),
        .o_Digit       (o_Digit),
        .o_Blank       (o_Blank),
        .o_Result_Valid(o_Result_Valid),
        .o_LED_1       (o_LED_1),
        .o_LED_2       (o_LED_2),
        .o_LED_3       (o_LED_3),
        .o_LED_4       (o_LED_4)
    );

    logic [9:0] dut_o;
    assign dut_o = {o_Digit, o_Blank, o_Result_Valid, o_LED_1, o_LED_2, o_LED_3, o_LED_4};

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode, registers, previous levels, and cycles since the blink last restarted
    int         m_st;
    logic [3:0] mE, mA, mB, m_prev;
    logic       m_op;
    logic [4:0] mR;
    int         m_age;

    typedef struct {
        logic [3:0] sw;
        logic [9:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [9:0] pk(input int d, input bit b, input bit rv,
                                      input bit l1, input bit l2, input bit l3, input bit l4);
        return {4'(d), b, rv, l1, l2, l3, l4};
    endfunction

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic m_step(input logic r, input logic [3:0] s);
        logic [3:0] ev;
        int         old, diff;
        bit         restart;
        if (r) begin
            m_st = M_EA; mE = 0; mA = 0; mB = 0; mR = 0; m_op = 0;
            m_prev = s; m_age = 0;
            return;
        end
        ev = s & ~m_prev;
        m_prev = s;
        old = m_st;
        restart = 0;
        if (ev[3]) begin
            m_st = M_EA; mE = 0; mA = 0; mB = 0; mR = 0;
            restart = 1;
        end else if (m_st == M_EX) begin
            if (m_op) begin
                diff = int'(mA) - int'(mB);
                mR = 5'(((diff + 16) % 16) + ((diff < 0) ? 16 : 0));
            end else begin
                mR = 5'(int'(mA) + int'(mB));
            end
            m_st = M_SH;
        end else if (ev[1]) begin
            if (m_st == M_EA) begin mA = mE; mE = 0; m_st = M_EB; end
            else if (m_st == M_EB) begin mB = mE; m_st = M_EX; end
            else begin mE = 0; m_st = M_EA; end
        end else if (ev[2]) begin
            if (m_st <= M_EB) m_op = !m_op;
        end else if (ev[0]) begin
            if (m_st <= M_EB) begin
                mE = 4'((int'(mE) + 1) % 16);
                restart = 1;
            end
        end
        if (m_st > M_EB || restart || m_st != old) m_age = 0;
        else m_age++;
    endtask

    function automatic logic [9:0] m_out();
        int  d;
        bit  b;
        d = (m_st == M_SH) ? int'(mR[3:0]) : int'(mE);
        b = (m_st <= M_EB) && (((m_age / N) % 2) == 1);
        return pk(d, b, m_st == M_SH, m_st == M_EA, m_st == M_EB, m_op,
                  (m_st == M_SH) && mR[4]);
    endfunction

    task automatic tick(input logic r, input logic [3:0] s);
        rst = r;
        sw  = s;
        m_step(r, s);
        @(posedge clk);
        #1;
        chk("model", dut_o, m_out());
    endtask

    task automatic press(input logic [3:0] s);
        tick(1'b0, s);
        tick(1'b0, 4'b0000);
    endtask

    task automatic enter(input int a, input int b);
        repeat (a) press(S);
        press(C);
        repeat (b) press(S);
        press(C);
    endtask

    task automatic add(input logic [3:0] s, input logic [9:0] e);
        vec_t v;
        v.sw  = s;
        v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        sw  = 4'b0000;

        // Add path 3 + 5, then the blink pattern and a STEP during the dark phase
        for (int k = 1; k <= 3; k++) begin
            add(S, pk(k, 0, 0, 1, 0, 0, 0));
            add(0, pk(k, 0, 0, 1, 0, 0, 0));
        end
        add(C, pk(0, 0, 0, 0, 1, 0, 0));
        add(0, pk(0, 0, 0, 0, 1, 0, 0));
        for (int k = 1; k <= 5; k++) begin
            add(S, pk(k, 0, 0, 0, 1, 0, 0));
            add(0, pk(k, 0, 0, 0, 1, 0, 0));
        end
        add(C, pk(5, 0, 0, 0, 0, 0, 0));
        add(0, pk(8, 0, 1, 0, 0, 0, 0));
        add(0, pk(8, 0, 1, 0, 0, 0, 0));
        add(C, pk(0, 0, 0, 1, 0, 0, 0));
        for (int k = 1; k <= 13; k++)
            add(0, pk(0, ((k / 4) % 2) == 1, 0, 1, 0, 0, 0));
        add(S, pk(1, 0, 0, 1, 0, 0, 0));
        for (int k = 1; k <= 4; k++)
            add(0, pk(1, k == 4, 0, 1, 0, 0, 0));

        tick(1'b1, 4'b0000);
        chk("reset_values", dut_o, pk(0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            tick(1'b0, tbl[i].sw);
            chk($sformatf("table[%0d]", i), dut_o, tbl[i].exp);
        end

        // 17 STEPs wrap through 0
        tick(1'b1, 4'b0000);
        repeat (17) press(S);
        chk("wrap_digit", {6'd0, o_Digit}, 10'd1);

        // 9 + 9 carries
        tick(1'b1, 4'b0000);
        enter(9, 9);
        chk("carry_9p9", dut_o, pk(2, 0, 1, 0, 0, 0, 1));
        for (int k = 0; k < 10; k++) tick(1'b0, 4'b0000);
        chk("show_no_blink", dut_o, pk(2, 0, 1, 0, 0, 0, 1));

        // Subtract with and without borrow
        press(C);
        press(O);
        chk("op_led", dut_o, pk(0, 0, 0, 1, 0, 1, 0));
        enter(2, 5);
        chk("sub_borrow", dut_o, pk(13, 0, 1, 0, 0, 1, 1));
        press(C);
        enter(5, 2);
        chk("sub_plain", dut_o, pk(3, 0, 1, 0, 0, 1, 0));

        // Reset from SHOW
        tick(1'b1, 4'b0000);
        chk("reset_in_show", dut_o, pk(0, 0, 0, 1, 0, 0, 0));

        // STEP and CONFIRM together: only the confirm acts
        tick(1'b0, 4'b0000);
        press(S);
        press(S);
        tick(1'b0, S | C);
        chk("step_cfm_same", dut_o, pk(0, 0, 0, 0, 1, 0, 0));
        tick(1'b0, 4'b0000);
        press(C);
        chk("step_cfm_A", dut_o, pk(2, 0, 1, 0, 0, 0, 0));

        // CLEAR with CONFIRM in ENTER_B
        tick(1'b1, 4'b0000);
        repeat (3) press(S);
        press(C);
        press(S);
        tick(1'b0, K | C);
        chk("clr_cfm", dut_o, pk(0, 0, 0, 1, 0, 0, 0));
        tick(1'b0, 4'b0000);
        press(C);
        press(C);
        chk("clr_zeroes_AB", dut_o, pk(0, 0, 1, 0, 0, 0, 0));

        // CLEAR during EXEC never reaches SHOW
        tick(1'b1, 4'b0000);
        press(S);
        press(C);
        press(S);
        tick(1'b0, C);
        chk("exec_state", dut_o, pk(1, 0, 0, 0, 0, 0, 0));
        tick(1'b0, K);
        chk("clr_in_exec", dut_o, pk(0, 0, 0, 1, 0, 0, 0));
        tick(1'b0, 4'b0000);
        chk("clr_exec_after", dut_o, pk(0, 0, 0, 1, 0, 0, 0));

        // STEP held through reset does not fire until re-pressed
        tick(1'b1, S);
        tick(1'b0, S);
        tick(1'b0, S);
        chk("held_thru_reset", {6'd0, o_Digit}, 10'd0);
        tick(1'b0, 4'b0000);
        tick(1'b0, S);
        chk("repress", {6'd0, o_Digit}, 10'd1);
        tick(1'b0, S);
        tick(1'b0, S);
        chk("held_one_event", {6'd0, o_Digit}, 10'd1);

        // Random levels against the model
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] s;
            s[0] = ($urandom_range(0, 2) == 0);
            s[1] = ($urandom_range(0, 3) == 0);
            s[2] = ($urandom_range(0, 5) == 0);
            s[3] = ($urandom_range(0, 24) == 0);
            tick($urandom_range(0, 299) == 0, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
